// File: rtl/s64x7_bus16_bridge.sv
// s64x7_bus16_bridge: splits one 64-bit Wishbone master cycle into up to four
// 16-bit slave cycles (one per active halfword lane). Read halfwords are
// assembled into m_dat_o and a single m_ack_o pulse completes the master cycle.
module s64x7_bus16_bridge (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [60:0] m_adr_i,
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    input  logic [7:0]  m_sel_i,
    input  logic        m_we_i,
    input  logic        m_vpa_i,
    input  logic [63:0] m_dat_i,
    output logic        m_ack_o,
    output logic [63:0] m_dat_o,
    output logic [62:0] s_adr_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic [1:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_vpa_o,
    output logic [15:0] s_dat_o,
    input  logic [15:0] s_dat_i,
    input  logic        s_ack_i
);

    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic        abort_q, abort_d;
    logic [60:0] adr_q;
    logic [7:0]  sel_q;
    logic        we_q, vpa_q;
    logic [63:0] wdat_q;
    logic [63:0] mdat_q;
    logic        latch, capture;
    logic [2:0]  first_lane, next_lane;
    logic        xfer;

    // Lowest active lane at index >= from; bit 2 flags that one was found.
    function automatic logic [2:0] find_lane(input logic [7:0] sel, input int from);
        logic [2:0] r;
        r = '0;
        for (int k = 3; k >= 0; k--) begin
            if (k >= from && sel[2*k +: 2] != 2'b00) r = {1'b1, 2'(k)};
        end
        return r;
    endfunction

    assign first_lane = find_lane(m_sel_i, 0);
    assign next_lane  = find_lane(sel_q, int'(lane_q) + 1);

    // FSM state, current lane and pending-abort flag.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            lane_q  <= 2'd0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            abort_q <= abort_d;
        end
    end

    // Next-state: accept in IDLE, walk active lanes in XFER, one ack cycle in DONE.
    // An abort seen at any point in a lane still lets that lane finish.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        abort_d = abort_q;
        latch   = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    latch   = 1'b1;
                    abort_d = 1'b0;
                    if (first_lane[2]) begin
                        state_d = XFER;
                        lane_d  = first_lane[1:0];
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            XFER: begin
                if (!m_cyc_i) abort_d = 1'b1;
                if (s_ack_i) begin
                    capture = !we_q;
                    if (abort_q || !m_cyc_i) begin
                        state_d = IDLE;
                        abort_d = 1'b0;
                    end else if (next_lane[2]) begin
                        lane_d = next_lane[1:0];
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and read-data assembly; unfetched lanes stay zero.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            adr_q  <= '0;
            sel_q  <= '0;
            we_q   <= 1'b0;
            vpa_q  <= 1'b0;
            wdat_q <= '0;
            mdat_q <= '0;
        end else begin
            if (latch) begin
                adr_q  <= m_adr_i;
                sel_q  <= m_sel_i;
                we_q   <= m_we_i;
                vpa_q  <= m_vpa_i;
                wdat_q <= m_dat_i;
                mdat_q <= '0;
            end
            if (capture) mdat_q[{lane_q, 4'b0000} +: 16] <= s_dat_i;
        end
    end

    // Slave outputs are decoded from registered state and zeroed outside XFER.
    assign xfer    = (state_q == XFER);
    assign s_cyc_o = xfer;
    assign s_stb_o = xfer;
    assign s_adr_o = xfer ? {adr_q, lane_q} : '0;
    assign s_sel_o = xfer ? sel_q[{lane_q, 1'b0} +: 2] : 2'b00;
    assign s_dat_o = xfer ? wdat_q[{lane_q, 4'b0000} +: 16] : 16'h0000;
    assign s_we_o  = xfer & we_q;
    assign s_vpa_o = xfer & vpa_q;
    assign m_ack_o = (state_q == DONE);
    assign m_dat_o = mdat_q;

endmodule
